data_mem: RTL and testbench

//  Parametrised data memory for the RISC-V core LSU; successor to the combinational instruction RAM.

---
 rtl/data_mem.sv | 203 ++++++++++++++++++++
 tb/tb_data_mem.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem
//  Purpose  : Byte-addressed, word-organised data memory for the LSU.
//             Handles RISC-V B/H/W loads and stores (signed and unsigned)
//             through byte-lane enables and sign/zero extension, with a
//             req/ready/rvalid handshake and configurable read latency.
//             Misaligned or illegal accesses complete with err_o set.
//  Ports    : clk_i     - clock, all state on rising edge
//             rst_n_i   - asynchronous active-low reset
//             req_i     - transaction request
//             we_i      - 1 = store, 0 = load
//             size_i    - funct3 access size (B/H/W/BU/HU)
//             addr_i    - byte address (upper bits wrap)
//             wd_i      - store data, right-aligned
//             ready_o   - request accepted on this edge when req_i is high
//             rvalid_o  - one-cycle completion pulse
//             rd_o      - load result, zero when rvalid_o is low
//             err_o     - completion was misaligned/illegal
//  Revision : 1.0  initial release
// ============================================================================
module data_mem #(
    parameter int WORDS     = 512,
    parameter int LATENCY   = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rd_o,
    output logic        err_o
);

    localparam int       c_IDX_W = $clog2(WORDS);
    localparam logic [2:0] c_SZ_B  = 3'b000;
    localparam logic [2:0] c_SZ_H  = 3'b001;
    localparam logic [2:0] c_SZ_W  = 3'b010;
    localparam logic [2:0] c_SZ_BU = 3'b100;
    localparam logic [2:0] c_SZ_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_cnt;
    logic [1:0]         w_cnt_nxt;
    logic               w_done;
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_off;
    logic               w_unused;
    logic               w_accept;
    logic               w_legal;
    logic [3:0]         w_be;
    logic               w_wr_en;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rword;
    logic [31:0]        w_shift;
    logic [31:0]        w_ldata;

    // Address bits above the array index are ignored, so accesses alias.
    assign w_idx    = addr_i[c_IDX_W+1:2];
    assign w_off    = addr_i[1:0];
    assign w_unused = ^addr_i[31:c_IDX_W+2];

    assign ready_o  = (r_state == ST_IDLE);
    assign w_accept = req_i & ready_o;

    // Access legality and store byte-lane enables.
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        case (size_i)
            c_SZ_B:  begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << w_off;
            end
            c_SZ_H:  begin
                w_legal = ~w_off[0];
                w_be    = 4'b0011 << w_off;
            end
            c_SZ_W:  begin
                w_legal = (w_off == 2'b00);
                w_be    = 4'b1111;
            end
            c_SZ_BU: w_legal = ~we_i;
            c_SZ_HU: w_legal = ~we_i & ~w_off[0];
            default: w_legal = 1'b0;
        endcase
    end

    assign w_wr_en = w_accept & we_i & w_legal;
    assign w_wdata = wd_i << {w_off, 3'b000};

    // Storage: contents are never reset, optionally zero at time 0.
    generate
        if (INIT_ZERO != 0) begin : g_mem_zero
            logic [31:0] r_mem [WORDS] = '{default: '0};
            always_ff @(posedge clk_i) begin
                if (w_wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_be[b]) begin
                            r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                        end
                    end
                end
            end
            assign w_rword = r_mem[w_idx];
        end else begin : g_mem_plain
            logic [31:0] r_mem [WORDS];
            always_ff @(posedge clk_i) begin
                if (w_wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_be[b]) begin
                            r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                        end
                    end
                end
            end
            assign w_rword = r_mem[w_idx];
        end
    endgenerate

    // Load lane alignment and extension, evaluated on the acceptance edge.
    assign w_shift = w_rword >> {w_off, 3'b000};

    always_comb begin
        w_ldata = w_shift;
        case (size_i)
            c_SZ_B:  w_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
            c_SZ_H:  w_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
            c_SZ_BU: w_ldata = {24'h000000, w_shift[7:0]};
            c_SZ_HU: w_ldata = {16'h0000, w_shift[15:0]};
            default: w_ldata = w_shift;
        endcase
    end

    // Latency sequencing: the counter is loaded with LATENCY-1 on accept and
    // completion fires on the edge where it would reach zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_i) begin
                    w_cnt_nxt = 2'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt <= 2'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 2'd0;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 2'd0;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rvalid <= w_done;
            if (w_accept) begin
                r_err   <= ~w_legal;
                r_rdata <= (w_legal && !we_i) ? w_ldata : 32'h0;
            end
        end
    end

    assign rvalid_o = r_rvalid;
    assign rd_o     = r_rvalid ? r_rdata : 32'h0;
    assign err_o    = r_rvalid & r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem
//  Purpose  : Self-checking bench for data_mem. Two instances (LATENCY 1
//             and 3) share the stimulus bus; sel routes req_i and the
//             outputs. Expected values come from a byte-level memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem;

    localparam int c_WORDS = 512;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel   = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [2:0]  size  = 3'b000;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wd    = 32'h0;

    logic        ready1, rvalid1, err1;
    logic        ready3, rvalid3, err3;
    logic [31:0] rd1, rd3;
    logic        ready, rvalid, err;
    logic [31:0] rd;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mdl [2][c_WORDS];

    always #5 clk = ~clk;

    data_mem #(.WORDS(c_WORDS), .LATENCY(1), .INIT_ZERO(1)) u_dut1 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .req_i   (req & ~sel),
        .we_i    (we),
        .size_i  (size),
        .addr_i  (addr),
        .wd_i    (wd),
        .ready_o (ready1),
        .rvalid_o(rvalid1),
        .rd_o    (rd1),
        .err_o   (err1)
    );

    data_mem #(.WORDS(c_WORDS), .LATENCY(3), .INIT_ZERO(1)) u_dut3 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .req_i   (req & sel),
        .we_i    (we),
        .size_i  (size),
        .addr_i  (addr),
        .wd_i    (wd),
        .ready_o (ready3),
        .rvalid_o(rvalid3),
        .rd_o    (rd3),
        .err_o   (err3)
    );

    assign ready  = sel ? ready3  : ready1;
    assign rvalid = sel ? rvalid3 : rvalid1;
    assign rd     = sel ? rd3     : rd1;
    assign err    = sel ? err3    : err1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory viewed as bytes; an access of n bytes at byte offset
    // off is legal when naturally aligned, with unsigned sizes load-only.
    task automatic ref_access(input int s, input bit w, input logic [2:0] sz,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] e_rd, output bit e_err);
        int n;
        bit sgn;
        int idx;
        int off;
        idx   = int'((a >> 2) % c_WORDS);
        off   = int'(a % 4);
        n     = 0;
        sgn   = 1'b0;
        case (sz)
            3'b000:  begin n = 1; sgn = 1'b1; end
            3'b001:  begin n = 2; sgn = 1'b1; end
            3'b010:  n = 4;
            3'b100:  n = 1;
            3'b101:  n = 2;
            default: n = 0;
        endcase
        if (n == 0) e_err = 1'b1;
        else        e_err = ((off % n) != 0) || (w && n < 4 && !sgn);
        e_rd = 32'h0;
        if (!e_err) begin
            for (int i = 0; i < n; i++) begin
                if (w) mdl[s][idx][8*(off+i) +: 8] = d[8*i +: 8];
                else   e_rd[8*i +: 8] = mdl[s][idx][8*(off+i) +: 8];
            end
            if (!w && sgn && n < 4 && e_rd[8*n-1]) e_rd = e_rd | (32'hFFFF_FFFF << (8*n));
        end
    endtask

    // Issue one access from a negedge with the selected instance idle, then
    // wait (bounded) for its completion and compare latency, data and error.
    task automatic op(input bit w, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input string tag, output logic [31:0] rd_obs);
        logic [31:0] e_rd;
        bit          e_err;
        int          k;
        int          lat;
        lat = sel ? 3 : 1;
        chk({tag, "_rdy"}, 32'(ready), 32'd1);
        we = w; size = sz; addr = a; wd = d; req = 1'b1;
        ref_access(int'(sel), w, sz, a, d, e_rd, e_err);
        @(negedge clk);
        req = 1'b0;
        k = 0;
        while (!rvalid && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, 32'(k), 32'(lat - 1));
        chk({tag, "_rd"}, rd, e_rd);
        chk({tag, "_err"}, 32'(err), 32'(e_err));
        rd_obs = rd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] e;
        bit          ee;
        logic [31:0] exp_q [$];

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < c_WORDS; i++)
                mdl[s][i] = 32'h0;

        // 1: reset held with clock running, then released mid-cycle
        repeat (3) @(negedge clk);
        chk("rst_ready1", 32'(ready1), 32'd1);
        chk("rst_ready3", 32'(ready3), 32'd1);
        chk("rst_rvalid", 32'({rvalid1, rvalid3}), 32'd0);
        chk("rst_rd", rd1 | rd3, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_nopulse", 32'({rvalid1, rvalid3}), 32'd0);
        end

        // 2: store then load a word, LATENCY 1
        sel = 1'b0;
        op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "t2_sw", r);
        op(1'b0, 3'b010, 32'h10, 32'h0, "t2_lw", r);
        chk("t2_lw_val", r, 32'hDEADBEEF);

        // 3: byte store, sub-word loads
        op(1'b1, 3'b000, 32'h11, 32'h0000007F, "t3_sb", r);
        op(1'b0, 3'b000, 32'h13, 32'h0, "t3_lb", r);
        chk("t3_lb_val", r, 32'hFFFFFFDE);
        op(1'b0, 3'b100, 32'h13, 32'h0, "t3_lbu", r);
        chk("t3_lbu_val", r, 32'h000000DE);
        op(1'b0, 3'b001, 32'h12, 32'h0, "t3_lh", r);
        chk("t3_lh_val", r, 32'hFFFFDEAD);
        op(1'b0, 3'b010, 32'h10, 32'h0, "t3_lw", r);
        chk("t3_lw_val", r, 32'hDEAD7FEF);

        // 4: illegal accesses leave memory untouched
        op(1'b1, 3'b010, 32'h20, 32'h12345678, "t4_pre", r);
        op(1'b1, 3'b001, 32'h21, 32'hFFFFFFFF, "t4_sh_mis", r);
        op(1'b0, 3'b010, 32'h22, 32'h0, "t4_lw_mis", r);
        op(1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, "t4_sbu", r);
        op(1'b0, 3'b010, 32'h20, 32'h0, "t4_lw", r);
        chk("t4_lw_val", r, 32'h12345678);
        @(negedge clk);
        chk("t4_pulse", 32'(rvalid), 32'd0);

        // 5: LATENCY 3 back-to-back stream, then address aliasing
        sel = 1'b1;
        for (int i = 0; i < 3; i++)
            op(1'b1, 3'b010, 32'h40 + 32'(4*i), $urandom, "t5_pre", r);
        @(negedge clk);
        chk("t5_pulse", 32'(rvalid), 32'd0);
        for (int c = 0; c <= 9; c++) begin
            chk($sformatf("t5_ready_c%0d", c), 32'(ready), 32'((c % 3) == 0));
            chk($sformatf("t5_rvalid_c%0d", c), 32'(rvalid), 32'(c > 0 && (c % 3) == 0));
            if (c > 0 && (c % 3) == 0) chk("t5_stream_rd", rd, exp_q.pop_front());
            if ((c % 3) == 0) begin
                if (c < 9) begin
                    we = 1'b0; size = 3'b010; addr = 32'h40 + 32'(4*(c/3)); req = 1'b1;
                    ref_access(1, 1'b0, 3'b010, addr, 32'h0, e, ee);
                    exp_q.push_back(e);
                end else begin
                    req = 1'b0;
                end
            end
            @(negedge clk);
        end
        op(1'b1, 3'b010, 32'h800, 32'hCAFEF00D, "t5_sw_alias", r);
        op(1'b0, 3'b010, 32'h0, 32'h0, "t5_lw_alias", r);
        chk("t5_alias_val", r, 32'hCAFEF00D);

        // 6: reset while a store is in flight
        we = 1'b1; size = 3'b010; addr = 32'h30; wd = 32'hA5A55A5A; req = 1'b1;
        ref_access(1, 1'b1, 3'b010, 32'h30, 32'hA5A55A5A, e, ee);
        @(negedge clk);
        req = 1'b0;
        chk("t6_busy", 32'(ready), 32'd0);
        #2 rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t6_rst_rvalid", 32'(rvalid), 32'd0);
        end
        #3 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t6_no_pulse", 32'(rvalid), 32'd0);
        end
        op(1'b0, 3'b010, 32'h30, 32'h0, "t6_lw", r);
        chk("t6_lw_val", r, 32'hA5A55A5A);

        // Random mix against the model, both latencies
        for (int t = 0; t < 300; t++) begin
            sel = 1'($urandom_range(0, 1));
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               ($urandom & 32'hFFFF_F800) | 32'($urandom_range(0, 127)),
               $urandom, "rnd", r);
        end
        @(negedge clk);
        chk("end_pulse", 32'(rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
